inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the main control decoder.
- Holds the PC and requests instructions from instruction memory over a req/gnt/rvalid handshake.
- Latches each returned word and presents opcode/funct to the decoder.
- Once the execute side signals completion, computes the next PC from the decoded Jump/Branch/NEqual/Jr signals and the ALU zero flag.

Parameters:
ADDR_W, 32, PC/imem address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request, high only in FETCH
imem_addr  output  ADDR_W  fetch address (= pc)
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  imem_rdata valid this cycle
imem_rdata  input  32  returned instruction word
inst_valid  output  1  inst/opcode/funct hold a live instruction
inst  output  32  latched instruction
opcode  output  6  inst[31:26]
funct  output  6  inst[5:0]
pc  output  ADDR_W  address of latched instruction
pc_plus4  output  ADDR_W  pc+4, link value for jal
exec_done  input  1  execute side finished current instruction; sample control inputs
jump  input  1  decoded Jump
branch  input  1  decoded Branch
nequal  input  1  decoded NEqual (bne)
jr  input  1  decoded Jr
alu_zero  input  1  ALU zero flag
rs_data  input  32  register rs value (jr target)
misalign  output  1  one-cycle pulse: jr target had nonzero [1:0]

Behaviour:
Reset (async, active-high):
- state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, misalign=0.
- Asserting rst mid-operation drops imem_req immediately and discards any in-flight fetch.
- imem is reset by the same rst; no stale rvalid arrives after reset.

FSM states IDLE, FETCH, WAIT, EXEC:
- IDLE: next cycle goes to FETCH; fetch is therefore issued the second edge after reset release.
- FETCH: imem_req=1 (combinational from state), imem_addr=pc.
  - gnt&rvalid same cycle (zero-latency memory): capture rdata into inst, set inst_valid, go EXEC.
  - gnt only: go WAIT.
  - rvalid without gnt: ignored.
- WAIT: imem_req=0. On rvalid, capture inst, set inst_valid, go EXEC.
- EXEC: inst_valid=1 and inst is stable. On exec_done:
  - load pc with next_pc;
  - clear inst_valid;
  - go FETCH.
  - inst keeps its old value until overwritten.

next_pc, priority order:
- jr: {rs_data[31:2],2'b00}. Pulse misalign if rs_data[1:0]!=0.
- jump: {pc_plus4[31:28], inst[25:0], 2'b00}.
- branch & (alu_zero ^ nequal): pc_plus4 + (sext(inst[15:0])<<2).
- else: pc_plus4.

Arithmetic and signal rules:
- All adds are modulo 2^ADDR_W. pc=32'hFFFF_FFFC gives pc_plus4=0 (wrap, no flag).
- Control inputs are sampled only in EXEC with exec_done; they are ignored elsewhere.
- exec_done outside EXEC is ignored.

Latency and throughput:
- Minimum 2 cycles per instruction (FETCH with gnt&rvalid, then EXEC with exec_done).
- Each WAIT cycle adds 1.

Decomposition:
Shared package fetch_pkg:
- fetch_state_t enum {IDLE, FETCH, WAIT, EXEC};
- opcode constants OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_BEQ 6'h04, OP_BNE 6'h05;
- FUNCT_JR 6'h08.

Sub-module next_pc_calc: purely combinational, takes pc_plus4, inst, rs_data and control inputs; returns next_pc and misalign_raw. The FSM and PC/inst registers stay in inst_fetch.

Test Plan:
- Reset release, gnt&rvalid tied high, rdata=32'h2008_0005, exec_done after 1 cycle each -> imem_addr sequence 0,4,8; opcode=6'h08 presented; inst_valid low during FETCH.
- pc=0x10, inst=beq imm=16'hFFFE, branch=1, alu_zero=1 -> next imem_addr=0x0C. Same with alu_zero=0 -> 0x14. bne (nequal=1) with alu_zero=0 -> 0x0C.
- pc=0x4000_0000, jump=1, inst[25:0]=26'h000_0100 -> next imem_addr=0x4000_0400; jal leaves pc_plus4=0x4000_0004 during EXEC.
- jr=1 with jump=1 also high, rs_data=0x0000_0123 -> imem_addr=0x0000_0120 (jr wins), misalign pulses for exactly 1 cycle.
- gnt at cycle n, rvalid at n+3 -> imem_req high only in cycle n, inst captured at n+3. exec_done pulsed while in WAIT -> no PC change.
- rst asserted while in WAIT -> imem_req=0, pc=RESET_PC, inst_valid=0 asynchronously; a fresh fetch of RESET_PC is issued 2 edges after release. pc=0xFFFF_FFFC sequential -> next imem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the fetch stage.
// Imported by inst_fetch and next_pc_calc.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jr > jump > taken branch > fall-through.
// Purely combinational; the caller decides when to use the result.
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic [25:0]       i_target,
  input  logic [31:0]       i_rs_data,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_nequal,
  input  logic              i_jr,
  input  logic              i_alu_zero,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_misalign_raw
);

  logic [ADDR_W-1:0] w_br_off;
  logic              w_taken;

  assign w_br_off = {{(ADDR_W-18){i_target[15]}}, i_target[15:0], 2'b00};
  assign w_taken  = i_branch & (i_alu_zero ^ i_nequal);

  // Priority select of the redirect target
  always_comb begin
    o_next_pc      = i_pc_plus4;
    o_misalign_raw = 1'b0;
    if (i_jr) begin
      o_next_pc      = {i_rs_data[ADDR_W-1:2], 2'b00};
      o_misalign_raw = |i_rs_data[1:0];
    end else if (i_jump) begin
      o_next_pc = {i_pc_plus4[ADDR_W-1:28], i_target, 2'b00};
    end else if (w_taken) begin
      o_next_pc = i_pc_plus4 + w_br_off;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem handshake, latched instruction.
// Redirects the PC once the execute side reports completion.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              exec_done,
  input  logic              jump,
  input  logic              branch,
  input  logic              nequal,
  input  logic              jr,
  input  logic              alu_zero,
  input  logic [31:0]       rs_data,
  output logic              misalign
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic              r_inst_valid;
  logic              r_misalign;
  logic              w_capture;
  logic              w_advance;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_misalign_raw;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc_plus4    (w_pc_plus4),
    .i_target      (r_inst[25:0]),
    .i_rs_data     (rs_data),
    .i_jump        (jump),
    .i_branch      (branch),
    .i_nequal      (nequal),
    .i_jr          (jr),
    .i_alu_zero    (alu_zero),
    .o_next_pc     (w_next_pc),
    .o_misalign_raw(w_misalign_raw)
  );

  // Next state plus capture/advance strobes
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (imem_gnt && imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = EXEC;
        end else if (imem_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          w_advance   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // PC, instruction latch and misalign pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= w_advance & w_misalign_raw;
      if (w_capture) begin
        r_inst       <= imem_rdata;
        r_inst_valid <= 1'b1;
      end
      if (w_advance) begin
        r_pc         <= w_next_pc;
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign imem_req   = (r_state == FETCH);
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign opcode     = r_inst[31:26];
  assign funct      = r_inst[5:0];
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed stimulus, behavioural model,
// per-cycle compare plus literal checkpoints.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        nequal = 1'b0;
  logic        jr = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic        misalign;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] JRW = 32'h03E0_0008;

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst),
    .opcode(opcode), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4),
    .exec_done(exec_done), .jump(jump), .branch(branch),
    .nequal(nequal), .jr(jr), .alu_zero(alu_zero),
    .rs_data(rs_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Model: where the stage is in its fetch/execute cycle
  // 0 = idle after reset, 1 = requesting, 2 = granted, 3 = holding
  int          m_step;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_mis;

  function automatic logic [31:0] model_next(
    logic [31:0] cur, logic [31:0] w,
    logic j, logic b, logic ne, logic r, logic z, logic [31:0] rs);
    logic [31:0] seq, off;
    seq = cur + 32'd4;
    off = {{16{w[15]}}, w[15:0]};
    if (r) return rs - (rs % 4);
    if (j) return (seq & 32'hF000_0000) + w[25:0] * 4;
    if (b && (z != ne)) return seq + off * 4;
    return seq;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_step <= 0;
      m_pc   <= 32'h0;
      m_inst <= 32'h0;
      m_mis  <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (m_step == 0) m_step <= 1;
      else if (m_step == 1) begin
        if (imem_gnt && imem_rvalid) begin
          m_inst <= imem_rdata;
          m_step <= 3;
        end else if (imem_gnt) m_step <= 2;
      end else if (m_step == 2) begin
        if (imem_rvalid) begin
          m_inst <= imem_rdata;
          m_step <= 3;
        end
      end else if (exec_done) begin
        m_pc   <= model_next(m_pc, m_inst, jump, branch, nequal,
                             jr, alu_zero, rs_data);
        m_mis  <= jr && (rs_data % 4 != 0);
        m_step <= 1;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    chk("req", {31'b0, imem_req}, {31'b0, m_step == 1});
    chk("addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("valid", {31'b0, inst_valid}, {31'b0, m_step == 3});
    chk("inst", inst, m_inst);
    chk("opcode", {26'b0, opcode}, {26'b0, m_inst[31:26]});
    chk("funct", {26'b0, funct}, {26'b0, m_inst[5:0]});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
  endtask

  // One zero-latency fetch followed by a one-cycle execute
  task automatic run_instr(
    input logic [31:0] w, input logic j, input logic b,
    input logic ne, input logic r, input logic z,
    input logic [31:0] rs, output logic [31:0] pp4);
    wait_req();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = w;
    exec_done = 1'b0;
    @(negedge clk);
    pp4 = pc_plus4;
    jump = j; branch = b; nequal = ne; jr = r;
    alu_zero = z; rs_data = rs; exec_done = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    jump = 0; branch = 0; nequal = 0; jr = 0;
    alu_zero = 0; rs_data = 0; exec_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pp;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_gnt = 1; imem_rvalid = 1; exec_done = 1;
    imem_rdata = 32'h2008_0005;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_req();
      chk("seq_addr", imem_addr, 32'(k * 4));
      chk("seq_fetch_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("seq_opcode", {26'b0, opcode}, 32'h08);
      chk("seq_exec_valid", {31'b0, inst_valid}, 32'd1);
    end
    @(negedge clk);
    chk("seq_addr3", imem_addr, 32'h0C);
    imem_gnt = 0; imem_rvalid = 0; exec_done = 0;

    run_instr(JRW, 0, 0, 0, 1, 0, 32'h10, pp);
    chk("jr_set", imem_addr, 32'h10);
    run_instr(32'h1000_FFFE, 0, 1, 0, 0, 1, 0, pp);
    chk("beq_taken", imem_addr, 32'h0C);
    run_instr(JRW, 0, 0, 0, 1, 0, 32'h10, pp);
    run_instr(32'h1000_FFFE, 0, 1, 0, 0, 0, 0, pp);
    chk("beq_not", imem_addr, 32'h14);
    run_instr(JRW, 0, 0, 0, 1, 0, 32'h10, pp);
    run_instr(32'h1400_FFFE, 0, 1, 1, 0, 0, 0, pp);
    chk("bne_taken", imem_addr, 32'h0C);

    run_instr(JRW, 0, 0, 0, 1, 0, 32'h4000_0000, pp);
    run_instr(32'h0C00_0100, 1, 0, 0, 0, 0, 0, pp);
    chk("jal_link", pp, 32'h4000_0004);
    chk("jal_addr", imem_addr, 32'h4000_0400);

    run_instr(JRW, 1, 0, 0, 1, 0, 32'h123, pp);
    chk("jr_prio", imem_addr, 32'h120);
    chk("mis_on", {31'b0, misalign}, 32'd1);
    @(negedge clk);
    chk("mis_off", {31'b0, misalign}, 32'd0);

    imem_gnt = 1;
    @(negedge clk);
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    imem_gnt = 0; exec_done = 1; jr = 1; rs_data = 32'h40;
    @(negedge clk);
    chk("wait_pc", pc, 32'h120);
    exec_done = 0; jr = 0; rs_data = 0;
    @(negedge clk);
    chk("wait_valid", {31'b0, inst_valid}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    chk("wait_inst", inst, 32'h20);
    chk("wait_valid2", {31'b0, inst_valid}, 32'd1);
    imem_rvalid = 0; exec_done = 1;
    @(negedge clk);
    chk("after_wait", imem_addr, 32'h124);
    exec_done = 0;

    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);

    run_instr(JRW, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, pp);
    chk("wrap_set", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, pp);
    chk("wrap_pp4", pp, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
